// File: rtl/axi_mem_pkg.sv
// Shared encodings, FSM states and helpers for the AXI4 slave memory.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Burst parameters held for the life of one burst.
    typedef struct packed {
        logic [7:0] len;
        logic [1:0] burst;
        logic       err;
    } burst_cfg_t;

    function automatic int size_log2(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_mem_if.sv
// AXI4 bus bundle between a master and the slave memory.
interface axi_mem_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic [3:0]          AWREGION;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic [3:0]          ARREGION;
    logic                ARVALID;
    logic                ARREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi_mem_addr_gen.sv
// Next word index and burst error flag for one engine.
// WRAP support is compiled in only with AXI_MEM_WRAP_BURST_EN.
module axi_mem_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int IDX_W     = 12,
    parameter int SIZE_LOG2 = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [1:0]       burst,
    input  logic [7:0]       len,
    input  logic [2:0]       size,
    output logic [IDX_W-1:0] next_idx,
    output logic             err
);
`ifdef AXI_MEM_WRAP_BURST_EN
    logic [IDX_W-1:0] mask;
    logic             len_ok;
`endif

    always_comb begin
        next_idx = idx;
        err      = (size != 3'(SIZE_LOG2));
`ifdef AXI_MEM_WRAP_BURST_EN
        mask     = IDX_W'(len);
        len_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`endif
        case (burst)
            BURST_FIXED: next_idx = idx;
            BURST_INCR:  next_idx = idx + IDX_W'(1);
`ifdef AXI_MEM_WRAP_BURST_EN
            // Low bits step inside the aligned window; high bits stay put.
            BURST_WRAP: begin
                next_idx = (idx & ~mask) | ((idx + IDX_W'(1)) & mask);
                if (!len_ok) err = 1'b1;
            end
`endif
            default:     err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory with independent single-burst read and write engines.
// Define AXI_MEM_WRAP_BURST_EN to accept WRAP bursts.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 4096
) (
    input  logic      clk,
    input  logic      rst_n,
    axi_mem_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = size_log2(DATA_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Write engine state
    w_state_e          w_state;
    burst_cfg_t        w_cfg;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_cnt;
    logic              w_lerr;
    logic              awready, wready, bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    // Read engine state
    r_state_e          r_state;
    burst_cfg_t        r_cfg;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_cnt;
    logic              arready, rvalid, rlast;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    logic [IDX_W-1:0]  wg_idx, wg_next, rg_idx, rg_next;
    logic [1:0]        wg_burst, rg_burst;
    logic [7:0]        wg_len, rg_len;
    logic [2:0]        wg_size, rg_size;
    logic              wg_err, rg_err;
    logic              mem_we;

    // In idle the generators judge the incoming request; afterwards they step the latched burst.
    always_comb begin
        if (w_state == W_IDLE) begin
            wg_idx   = bus.AWADDR[OFF +: IDX_W];
            wg_burst = bus.AWBURST;
            wg_len   = bus.AWLEN;
            wg_size  = bus.AWSIZE;
        end else begin
            wg_idx   = w_idx;
            wg_burst = w_cfg.burst;
            wg_len   = w_cfg.len;
            wg_size  = 3'(OFF);
        end
        if (r_state == R_IDLE) begin
            rg_idx   = bus.ARADDR[OFF +: IDX_W];
            rg_burst = bus.ARBURST;
            rg_len   = bus.ARLEN;
            rg_size  = bus.ARSIZE;
        end else begin
            rg_idx   = r_idx;
            rg_burst = r_cfg.burst;
            rg_len   = r_cfg.len;
            rg_size  = 3'(OFF);
        end
    end

    axi_mem_addr_gen #(.IDX_W(IDX_W), .SIZE_LOG2(OFF)) u_wgen (
        .idx(wg_idx), .burst(wg_burst), .len(wg_len), .size(wg_size),
        .next_idx(wg_next), .err(wg_err)
    );

    axi_mem_addr_gen #(.IDX_W(IDX_W), .SIZE_LOG2(OFF)) u_rgen (
        .idx(rg_idx), .burst(rg_burst), .len(rg_len), .size(rg_size),
        .next_idx(rg_next), .err(rg_err)
    );

    // Gated by rst_n so a beat coinciding with reset is dropped.
    assign mem_we = (w_state == W_DATA) && bus.WVALID && !w_cfg.err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.WSTRB[b]) mem[w_idx][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_cfg   <= '0;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_lerr  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awready && bus.AWVALID) begin
                        w_cfg   <= '{len: bus.AWLEN, burst: bus.AWBURST, err: wg_err};
                        w_idx   <= bus.AWADDR[OFF +: IDX_W];
                        w_cnt   <= bus.AWLEN;
                        w_lerr  <= 1'b0;
                        bid     <= bus.AWID;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.WVALID) begin
                        w_idx <= wg_next;
                        if (w_cnt == 8'd0) begin
                            // Beat counter ends the burst; WLAST only colours the response.
                            bresp   <= (w_cfg.err || w_lerr || !bus.WLAST) ? RESP_SLVERR : RESP_OKAY;
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt - 8'd1;
                            if (bus.WLAST) w_lerr <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cfg   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arready && bus.ARVALID) begin
                        r_cfg   <= '{len: bus.ARLEN, burst: bus.ARBURST, err: rg_err};
                        r_idx   <= rg_next;
                        r_cnt   <= bus.ARLEN;
                        rid     <= bus.ARID;
                        rdata   <= rg_err ? '0 : mem[rg_idx];
                        rresp   <= rg_err ? RESP_SLVERR : RESP_OKAY;
                        rlast   <= (bus.ARLEN == 8'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            // r_idx already points at the beat being fetched here.
                            rdata <= r_cfg.err ? '0 : mem[rg_idx];
                            r_idx <= rg_next;
                            r_cnt <= r_cnt - 8'd1;
                            rlast <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.AWREADY = awready;
    assign bus.WREADY  = wready;
    assign bus.BVALID  = bvalid;
    assign bus.BID     = bid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = arready;
    assign bus.RVALID  = rvalid;
    assign bus.RLAST   = rlast;
    assign bus.RID     = rid;
    assign bus.RRESP   = rresp;
    assign bus.RDATA   = rdata;

    logic unused;
    assign unused = ^{bus.AWREGION, bus.ARREGION, bus.AWADDR, bus.ARADDR, r_cnt, w_cnt};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave (DATA_W=64): table of write/read-back pairs plus corner sequences.
module tb_axi_mem_slave;
    localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, BAD = 2'b11;
    localparam logic [1:0] OK = 2'b00, SLV = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_if #(.DATA_W(64), .ADDR_W(32), .ID_W(4)) bus ();

    axi_mem_slave #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .MEM_DEPTH(4096)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    typedef struct {
        logic [31:0]      waddr;
        logic [7:0]       wlen;
        logic [1:0]       wburst;
        logic [2:0]       wsize;
        logic [63:0]      wbase;
        logic [1:0]       exp_bresp;
        logic [31:0]      raddr;
        logic [7:0]       rlen;
        logic [1:0]       rburst;
        logic [2:0]       rsize;
        logic [1:0]       exp_rresp;
        logic [3:0][63:0] exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic        wl [16];
    logic [63:0] rd [16];
    logic [1:0]  rr [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout", name);
    endtask

    function automatic vec_t mk(logic [31:0] wa, logic [7:0] wln, logic [1:0] wb, logic [2:0] wsz,
                                logic [63:0] wbase, logic [1:0] eb, logic [31:0] ra, logic [7:0] rln,
                                logic [1:0] rb, logic [2:0] rsz, logic [1:0] er,
                                logic [63:0] e0, logic [63:0] e1, logic [63:0] e2, logic [63:0] e3);
        vec_t v;
        v.waddr = wa; v.wlen = wln; v.wburst = wb; v.wsize = wsz; v.wbase = wbase; v.exp_bresp = eb;
        v.raddr = ra; v.rlen = rln; v.rburst = rb; v.rsize = rsz; v.exp_rresp = er;
        v.exp_rd = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, output logic [1:0] resp);
        int n;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.AWREADY) break;
            if (++n > 50) begin timeout("aw"); break; end
        end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        chk("wready_after_aw", bus.WREADY, 1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.WDATA = wd[i]; bus.WSTRB = ws[i]; bus.WLAST = wl[i]; bus.WVALID = 1'b1;
            n = 0;
            while (1) begin
                @(negedge clk);
                if (bus.WREADY) break;
                if (++n > 50) begin timeout("w"); break; end
            end
            @(posedge clk); #1;
            if (i < int'(len)) chk("no_early_bvalid", bus.BVALID, 0);
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        chk("bvalid_after_last", bus.BVALID, 1);
        chk("bid", bus.BID, id);
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        chk("bvalid_drop", bus.BVALID, 0);
        chk("awready_after_b", bus.AWREADY, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit stall);
        int n, beat, cyc;
        logic [63:0] held;
        bit held_v;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.ARREADY) break;
            if (++n > 50) begin timeout("ar"); break; end
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        chk("rvalid_after_ar", bus.RVALID, 1);
        beat = 0; cyc = 0; held_v = 0; held = '0;
        while (beat <= int'(len) && cyc < 100) begin
            bus.RREADY = stall ? cyc[0] : 1'b1;
            @(negedge clk);
            if (bus.RVALID) begin
                if (held_v) chk("stall_stable", bus.RDATA, held);
                if (bus.RREADY) begin
                    rd[beat] = bus.RDATA;
                    rr[beat] = bus.RRESP;
                    chk("rlast", bus.RLAST, 64'(beat == int'(len)));
                    chk("rid", bus.RID, id);
                    beat++;
                    held_v = 0;
                end else begin
                    held = bus.RDATA;
                    held_v = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.RREADY = 1'b0;
        if (beat <= int'(len)) timeout("r_beats");
        chk("rvalid_drop", bus.RVALID, 0);
        chk("arready_back", bus.ARREADY, 1);
    endtask

    initial begin
        vec_t tbl [9];
        logic [1:0] resp;

        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWREGION = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARREGION = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        tbl[0] = mk(32'h100, 3, INC, 3, 64'hA0, OK, 32'h100, 3, INC, 3, OK, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
        tbl[1] = mk(32'h200, 2, FIX, 3, 64'hB0, OK, 32'h200, 2, FIX, 3, OK, 64'hB2, 64'hB2, 64'hB2, 0);
        tbl[2] = mk(32'h30B, 1, INC, 3, 64'hC0, OK, 32'h308, 1, INC, 3, OK, 64'hC0, 64'hC1, 0, 0);
        tbl[3] = mk(32'h8400, 0, INC, 3, 64'hD0, OK, 32'h400, 0, INC, 3, OK, 64'hD0, 0, 0, 0);
        tbl[4] = mk(32'h7FF8, 1, INC, 3, 64'hE0, OK, 32'h0, 0, INC, 3, OK, 64'hE1, 0, 0, 0);
        tbl[5] = mk(32'h100, 0, INC, 2, 64'hF0, SLV, 32'h100, 0, INC, 3, OK, 64'hA0, 0, 0, 0);
        tbl[6] = mk(32'h108, 1, BAD, 3, 64'h90, SLV, 32'h108, 1, INC, 3, OK, 64'hA1, 64'hA2, 0, 0);
        tbl[7] = mk(32'h208, 0, INC, 3, 64'h55, OK, 32'h200, 1, INC, 2, SLV, 0, 0, 0, 0);
`ifdef AXI_MEM_WRAP_BURST_EN
        tbl[8] = mk(32'h0, 3, INC, 3, 64'h10, OK, 32'h18, 3, WRP, 3, OK, 64'h13, 64'h10, 64'h11, 64'h12);
`else
        tbl[8] = mk(32'h0, 3, INC, 3, 64'h10, OK, 32'h18, 3, WRP, 3, SLV, 0, 0, 0, 0);
`endif

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_wready", bus.WREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_arready", bus.ARREADY, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_rlast", bus.RLAST, 0);
        chk("rst_bid_bresp", {bus.BID, bus.BRESP}, 0);
        chk("rst_rid_rresp", {bus.RID, bus.RRESP}, 0);
        chk("rst_rdata", bus.RDATA, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_awready", bus.AWREADY, 1);
        chk("post_rst_arready", bus.ARREADY, 1);

        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = tbl[k].wbase + 64'(i);
                ws[i] = 8'hFF;
                wl[i] = (i == int'(tbl[k].wlen));
            end
            do_write(tbl[k].waddr, tbl[k].wlen, tbl[k].wsize, tbl[k].wburst, 4'(k), resp);
            chk($sformatf("v%0d_bresp", k), resp, tbl[k].exp_bresp);
            do_read(tbl[k].raddr, tbl[k].rlen, tbl[k].rsize, tbl[k].rburst, 4'(k + 3), 1'b0);
            for (int i = 0; i <= int'(tbl[k].rlen); i++) begin
                chk($sformatf("v%0d_rdata%0d", k, i), rd[i], tbl[k].exp_rd[i]);
                chk($sformatf("v%0d_rresp%0d", k, i), rr[i], tbl[k].exp_rresp);
            end
        end

        // Byte strobes, then read back with RREADY toggling
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF; wl[0] = 1'b1;
        do_write(32'h0, 0, 3, INC, 4'h1, resp);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        do_write(32'h0, 0, 3, INC, 4'h2, resp);
        chk("strb_bresp", resp, OK);
        do_read(32'h0, 1, 3, INC, 4'h5, 1'b1);
        chk("strb_rdata0", rd[0], 64'hFFFF_FFFF_0000_0000);
        chk("strb_rdata1", rd[1], 64'h11);

        // WLAST early, then WLAST missing
        wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
        wl[0] = 1'b1; wl[1] = 1'b0;
        do_write(32'h300, 1, 3, INC, 4'h6, resp);
        chk("wlast_early_bresp", resp, SLV);
        wl[0] = 1'b0; wl[1] = 1'b0;
        do_write(32'h300, 1, 3, INC, 4'h7, resp);
        chk("wlast_missing_bresp", resp, SLV);

        // Reset in the middle of an 8-beat write
        bus.AWID = 4'h9; bus.AWADDR = 32'h600; bus.AWLEN = 8'd7; bus.AWSIZE = 3'd3;
        bus.AWBURST = INC; bus.AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.WDATA = 64'h60 + 64'(i); bus.WSTRB = 8'hFF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            @(posedge clk); #1;
        end
        bus.WDATA = 64'h62;
        rst_n = 1'b0;
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        chk("midrst_wready", bus.WREADY, 0);
        chk("midrst_bvalid", bus.BVALID, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_awready", bus.AWREADY, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_bvalid", bus.BVALID, 0);
        end
        do_read(32'h600, 1, 3, INC, 4'hA, 1'b0);
        chk("midrst_beat0", rd[0], 64'h60);
        chk("midrst_beat1", rd[1], 64'h61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Parametrised synthesizable AXI4 slave memory that answers the `tpu` master's read and write channels inside the top-level `harness`. It replaces the unconnected port stubs with a working backing store for end-to-end runs.
- Generalised in data width, depth and ID width.
- Independent read and write engines, each handling one burst at a time.
- Supports FIXED/INCR bursts (WRAP optional), byte strobes and error responses.

## Interface
- `DATA_W`, 64, data bus width in bits; power of two, ≥32
- `ADDR_W`, 32, byte address width
- `ID_W`, 4, AXI ID width
- `MEM_DEPTH`, 4096, number of DATA_W-bit words; power of two
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `AWID`/`AWADDR`/`AWLEN`/`AWSIZE`/`AWBURST`/`AWREGION`  in  ID_W/ADDR_W/8/3/2/4  write address; AWREGION ignored
- `AWVALID` in 1, `AWREADY` out 1  write address handshake
- `WDATA` in DATA_W, `WSTRB` in DATA_W/8, `WLAST` in 1, `WVALID` in 1, `WREADY` out 1  write data
- `BID` out ID_W, `BRESP` out 2, `BVALID` out 1, `BREADY` in 1  write response
- `ARID`/`ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST`/`ARREGION`  in  ID_W/ADDR_W/8/3/2/4  read address; ARREGION ignored
- `ARVALID` in 1, `ARREADY` out 1  read address handshake
- `RID` out ID_W, `RDATA` out DATA_W, `RRESP` out 2, `RLAST` out 1, `RVALID` out 1, `RREADY` in 1  read data

## Operation
- Word index = (addr >> log2(DATA_W/8)) mod MEM_DEPTH. Out-of-range addresses alias; they do not error. Low byte-offset bits are ignored.
- Beats per burst = AxLEN+1.
- FIXED: every beat uses the same index.
- INCR: index +1 per beat, wrapping modulo MEM_DEPTH.
- AxSIZE ≠ log2(DATA_W/8), or burst = 2'b11: the burst is still fully consumed or produced, with response SLVERR (2'b10).
  - Writes to memory are suppressed.
  - RDATA = 0.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, address, length and burst, then go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set and advances the beat counter. After the final counted beat, go to W_RESP.
  - W_RESP: BVALID=1, BID = latched ID. Hold until BREADY, then return to W_IDLE.
  - BRESP = OKAY (2'b00), or SLVERR on a size/burst error or on a WLAST mismatch (WLAST not set on the final beat, or set early). The beat counter, not WLAST, ends the burst.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, go to R_DATA.
  - R_DATA: RVALID=1, RID = latched ID. RLAST=1 on the final beat. After the final beat's R handshake, return to R_IDLE.
- Read and write engines are fully independent. A same-cycle write and read-fetch of the same word returns the old data.
- Memory contents are not reset.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0.
- First cycle after rst_n=1: AWREADY=1 and ARREADY=1.
- Write path:
  - AW handshake in cycle N → WREADY=1 in N+1.
  - Final W beat in cycle M → BVALID=1 in M+1.
  - B handshake in cycle K → AWREADY=1 in K+1.
- Read path:
  - AR handshake in cycle N → RVALID with beat 0 in N+1 (registered memory read).
  - With RREADY held high, one beat per cycle. The next beat's data is fetched on the handshake cycle.
  - RVALID=0 in the cycle after the last handshake; ARREADY=1 in that same cycle.
- While RVALID=1 && RREADY=0: RDATA, RID, RRESP and RLAST stay stable.
- Once asserted, BVALID and RVALID are never dropped without a handshake.
- rst_n=0 mid-burst: both FSMs go to idle on the next edge, outputs take reset values, and the pending B/R is discarded. Memory writes already performed persist.

## Configuration
- `AXI_MEM_WRAP_BURST_EN` defined: WRAP bursts (2'b10) are supported.
  - AxLEN must be 1, 3, 7 or 15. Any other length gives SLVERR.
  - Index wraps within an aligned window of AxLEN+1 words.
- `AXI_MEM_WRAP_BURST_EN` undefined: WRAP is treated as an error burst (SLVERR, no memory writes, RDATA=0).

## Structure
- Package `axi_mem_pkg`:
  - burst encodings (FIXED/INCR/WRAP)
  - response codes (OKAY/SLVERR)
  - write/read state enums
  - helper function for log2(DATA_W/8)
- Sub-module `axi_mem_addr_gen`: given the current index, burst type and length, produces the next index and an error flag. Instantiated once per engine.
- Memory is one behavioural array of MEM_DEPTH × DATA_W with per-byte write enables.

## Test plan
All scenarios use DATA_W=64, AxSIZE=3.
- Reset: hold rst_n=0 for 5 cycles → all outputs 0. Release → AWREADY=ARREADY=1 in the next cycle.
- INCR write/read-back: AWADDR=0x100, AWLEN=3, data 0xA0..0xA3 → BRESP=OKAY. Then ARADDR=0x100, ARLEN=3 → RDATA 0xA0..0xA3, RLAST on beat 3, RRESP=OKAY.
- Strobe plus stall: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with WSTRB=0x0F. Read with RREADY toggling 1/0 → RDATA=0xFFFF_FFFF_0000_0000, held stable during stalls.
- Error and WLAST mismatch:
  - AWSIZE=2 write → BRESP=SLVERR, memory unchanged.
  - AWLEN=1 burst with WLAST on beat 0 → SLVERR after 2 beats.
- WRAP: ARADDR=0x18, ARLEN=3, burst WRAP.
  - With `AXI_MEM_WRAP_BURST_EN`: word order 3,0,1,2.
  - Without it: 4 beats of RDATA=0, RRESP=SLVERR.
- Mid-burst reset: assert rst_n=0 during beat 2 of an AWLEN=7 write → no BVALID. Idle after release; beats 0–1 retained in memory.
